// File: rtl/simd_lane_sequencer.sv
// Issue/collect front end for simd_alu: packs a scalar (a,b) stream into one vector,
// holds it on the ALU bus for the ALU latency, then streams the result back one lane at a time.
module simd_lane_sequencer #(
  parameter int LANES   = 8,
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [2:0]                    in_op,
  input  logic                          in_last,
  output logic [LANES*WIDTH-1:0]        alu_a,
  output logic [LANES*WIDTH-1:0]        alu_b,
  output logic [2:0]                    alu_op,
  input  logic [LANES*WIDTH-1:0]        alu_y,
  input  logic                          alu_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_y,
  output logic [$clog2(LANES)-1:0]      out_lane,
  output logic                          out_last
);

  localparam int LW  = $clog2(LANES);
  localparam int VW  = LANES * WIDTH;
  localparam int WCW = $clog2(ALU_LAT + 2);
  localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ALU_LAT);

  // Padding lanes carry b=1 so a divide on an unfilled lane never sees a zero divisor.
  function automatic logic [VW-1:0] pad_ones();
    logic [VW-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i*WIDTH +: WIDTH] = WIDTH'(1);
    return p;
  endfunction
  localparam logic [VW-1:0] PAD_B = pad_ones();

  typedef enum logic [1:0] {FILL, WAIT_ALU, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [LW-1:0]  cnt, idx;
  logic [LW:0]    n;
  logic [WCW-1:0] wcnt;
  logic [VW-1:0]  a_buf, b_buf, res;
  logic [2:0]     op_r;
  logic           fill_done, last_lane, in_hs, out_hs;
  logic [WIDTH-1:0] res_sel;

  assign alu_a  = a_buf;
  assign alu_b  = b_buf;
  assign alu_op = op_r;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fill_done = (cnt == LAST_LANE) || in_last;
    last_lane = ({1'b0, idx} == (n - 1'b1));
    res_sel   = '0;
    for (int i = 0; i < LANES; i++)
      if (idx == LW'(i)) res_sel = res[i*WIDTH +: WIDTH];
    case (state)
      FILL: begin
        in_ready = !rst;
        if (in_valid && !rst && fill_done) state_nxt = WAIT_ALU;
      end
      WAIT_ALU: begin
        if (wcnt == WAIT_LAST && alu_valid) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && last_lane) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid && out_ready;
    out_last = out_valid && last_lane;
    out_lane = idx;
    out_y    = out_valid ? res_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      idx   <= '0;
      n     <= '0;
      wcnt  <= '0;
      a_buf <= '0;
      b_buf <= PAD_B;
      op_r  <= 3'b000;
      res   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FILL: begin
          if (in_hs) begin
            for (int i = 0; i < LANES; i++) begin
              if (cnt == LW'(i)) begin
                a_buf[i*WIDTH +: WIDTH] <= in_a;
                b_buf[i*WIDTH +: WIDTH] <= in_b;
              end
            end
            if (cnt == '0) op_r <= in_op;
            if (fill_done) begin
              n    <= {1'b0, cnt} + 1'b1;
              wcnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_ALU: begin
          // Counter saturates on the last wait cycle until the ALU reports valid.
          if (wcnt != WAIT_LAST) begin
            wcnt <= wcnt + 1'b1;
          end else if (alu_valid) begin
            res <= alu_y;
            idx <= '0;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (last_lane) begin
              cnt   <= '0;
              idx   <= '0;
              a_buf <= '0;
              b_buf <= PAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Bench for simd_lane_sequencer: a behavioural one-stage ALU model, an element driver and
// an output monitor checking every result handshake against an expected queue.
module tb_simd_lane_sequencer;
  localparam int LANES = 8, WIDTH = 16, ALU_LAT = 1;
  localparam int LW = 3, VW = LANES * WIDTH, EW = 1 + LW + WIDTH;
  localparam int TMO = 300;

  logic clk, rst;
  logic in_valid, in_ready, in_last;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0] in_op, alu_op;
  logic [VW-1:0] alu_a, alu_b, alu_y;
  logic alu_valid, alu_hold;
  logic out_valid, out_ready, out_last;
  logic [WIDTH-1:0] out_y;
  logic [LW-1:0] out_lane;

  simd_lane_sequencer #(.LANES(LANES), .WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_last(in_last), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_valid(alu_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_lane(out_lane), .out_last(out_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- ALU model ----------------
  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op, input logic [WIDTH-1:0] a, b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a * b;
      3'b011:  return (b == 0) ? {WIDTH{1'b1}} : a / b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [VW-1:0] alu_vec(input logic [2:0] op, input logic [VW-1:0] a, b);
    logic [VW-1:0] y;
    for (int i = 0; i < LANES; i++) y[i*WIDTH +: WIDTH] = alu_fn(op, a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]);
    return y;
  endfunction

  always @(posedge clk) alu_y <= alu_vec(alu_op, alu_a, alu_b);
  assign alu_valid = !alu_hold;

  // ---------------- checking ----------------
  int errors = 0, checks = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- output consumer ----------------
  int ready_mode = 0;
  int rpat = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((rpat % 4 == 0) || (rpat % 4 == 3));
      rpat++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int pops = 0;
  int last_out_cyc = -10;
  logic prev_stall = 1'b0;
  logic [EW-1:0] prev_out, e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_drain", in_ready, 0);
        if (prev_stall) check("stall_hold", {out_last, out_lane, out_y}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("out", {out_last, out_lane, out_y}, e);
          pops++;
          if (out_last) last_out_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_lane, out_y};
    end
  end

  // ---------------- driver tasks ----------------
  logic [WIDTH-1:0] va[LANES], vb[LANES];
  logic [2:0] vop[LANES];

  task automatic drive_elem(input logic [WIDTH-1:0] a, b, input logic [2:0] op, input logic last,
                            output int acc_cyc);
    int g;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_last = last;
    g = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      g++;
      if (g > TMO) begin check("in_timeout", in_ready, 1); break; end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input int n, input bit last_full, output int first_cyc);
    int c;
    logic lst;
    for (int k = 0; k < n; k++) begin
      lst = (k == n - 1) && ((n < LANES) || last_full);
      exp_q.push_back({(k == n - 1), 3'(k), alu_fn(vop[0], va[k], vb[k])});
      drive_elem(va[k], vb[k], vop[k], lst, c);
      if (k == 0) first_cyc = c;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < TMO) begin @(posedge clk); g++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_vec(input logic [2:0] op);
    for (int i = 0; i < LANES; i++) begin
      va[i] = WIDTH'($urandom_range(0, 65535));
      vb[i] = WIDTH'($urandom_range(0, 255));
      vop[i] = op;
    end
  endtask

  // ---------------- main sequence ----------------
  int fc, base, g;
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_last = 1'b0; alu_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_out_y", out_y, 0);
    check("rst_alu_op", alu_op, 0);
    for (int i = 0; i < LANES; i++) begin
      check("rst_pad_a", alu_a[i*WIDTH +: WIDTH], 0);
      check("rst_pad_b", alu_b[i*WIDTH +: WIDTH], 1);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("fill_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // full ADD vector: 11..18
    for (int i = 0; i < LANES; i++) begin va[i] = WIDTH'(i + 1); vb[i] = 16'd10; vop[i] = 3'b000; end
    send_vec(LANES, 1'b0, fc); idle();
    wait_drain();

    // partial DIV with in_last on the third element
    va[0] = 16'd100; va[1] = 16'd50; va[2] = 16'd7;
    vb[0] = 16'd10;  vb[1] = 16'd0;  vb[2] = 16'd2;
    for (int i = 0; i < LANES; i++) vop[i] = 3'b011;
    send_vec(3, 1'b0, fc); idle();
    @(negedge clk);
    check("wait_in_ready", in_ready, 0);
    check("div_alu_op", alu_op, 3);
    for (int i = 3; i < LANES; i++) check("div_pad_b", alu_b[i*WIDTH +: WIDTH], 1);
    wait_drain();

    // backpressure 1,0,0,1 on a random SUB vector
    ready_mode = 1;
    rand_vec(3'b001);
    send_vec(LANES, 1'b0, fc); idle();
    @(negedge clk);
    check("wait_in_ready_bp", in_ready, 0);
    wait_drain();
    ready_mode = 0;

    // op latched from lane 0 only; ALU valid withheld for a while; in_last on lane 7
    for (int i = 0; i < LANES; i++) begin va[i] = 16'd3; vb[i] = 16'd4; vop[i] = (i == 0) ? 3'b010 : 3'b001; end
    send_vec(LANES, 1'b1, fc); idle();
    alu_hold = 1'b1;
    repeat (5) begin @(negedge clk); check("alu_hold_wait", out_valid, 0); end
    @(posedge clk); #1 alu_hold = 1'b0;
    wait_drain();

    // reset in the middle of DRAIN after two results
    rand_vec(3'b010);
    send_vec(LANES, 1'b0, fc); idle();
    base = pops; g = 0;
    while (pops < base + 2 && g < TMO) begin @(posedge clk); g++; end
    check("rst_mid_pops", pops, base + 2);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rand_vec(3'b000);
    send_vec(5, 1'b0, fc); idle();
    wait_drain();

    // back-to-back vectors with in_valid held high
    rand_vec(3'b000);
    send_vec(LANES, 1'b0, fc);
    va[0] = 16'd1234; vb[0] = 16'd4321; vop[0] = 3'b001;
    send_vec(1, 1'b0, fc);
    check("b2b_first_accept", fc, last_out_cyc + 1);
    rand_vec(3'b011);
    send_vec(LANES, 1'b1, fc);
    check("b2b_second_accept", fc, last_out_cyc + 1);
    idle();
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
